// File: rtl/mips_single_cycle_core.sv
// Single-cycle 32-bit MIPS subset core: PC, instruction ROM, 32x32 register file, data RAM, ALU, decode.
// Latency: one instruction retires per rising clk edge; fetch, decode, execute and load read are combinational.
// No backpressure: the core advances every cycle. Defining MIPS_TRACE_EN adds a per-edge $display trace.
// IMEM_WORDS and DMEM_WORDS are powers of two, so index wrap is simply the low address bits.
// imem is never written by this logic: the IMEM_FILE image is preloaded by the simulation/FPGA flow.
module mips_single_cycle_core #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64,
  parameter     IMEM_FILE  = "program.hex"
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] rf_q [32];
  logic [31:0] dmem_q [DMEM_WORDS];
  logic [31:0] pc_q, pc_d;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, pc_plus4, rs_val, rt_val, alu_b, alu_res, mem_rdat;
  logic        rf_we, mem_we, alu_src, branch, jump, funct_ok, zero;
  logic [1:0]  reg_dst, mem_to_reg, alu_op;
  logic [2:0]  alu_ctl;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  assign pc       = pc_q;
  assign instr    = imem[pc_q[IAW+1:2]];
  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign pc_plus4 = pc_q + 32'd4;
  // $0 is cleared on reset and never written, so it always reads zero.
  assign rs_val   = rf_q[rs];
  assign rt_val   = rf_q[rt];
  assign mem_rdat = dmem_q[alu_res[DAW+1:2]];

  // Main decode: unsupported opcodes and R-type functs keep every enable low (NOP).
  always_comb begin
    rf_we      = 1'b0;
    mem_we     = 1'b0;
    alu_src    = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_op     = 2'b00;
    funct_ok   = (funct == 6'b100000) || (funct == 6'b100010) || (funct == 6'b100100) ||
                 (funct == 6'b100101) || (funct == 6'b101010);
    case (op)
      6'b000000: begin
        rf_we   = funct_ok;
        reg_dst = 2'b01;
        alu_op  = 2'b10;
      end
      6'b001000: begin
        rf_we   = 1'b1;
        alu_src = 1'b1;
      end
      6'b100011: begin
        rf_we      = 1'b1;
        alu_src    = 1'b1;
        mem_to_reg = 2'b01;
      end
      6'b101011: begin
        mem_we  = 1'b1;
        alu_src = 1'b1;
      end
      6'b000100: begin
        branch = 1'b1;
        alu_op = 2'b01;
      end
      6'b000010: jump = 1'b1;
      6'b000011: begin
        jump       = 1'b1;
        rf_we      = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
      end
      default: ;
    endcase
  end

  // ALU control from ALUOp and funct.
  always_comb begin
    alu_ctl = ALU_ADD;
    case (alu_op)
      2'b01: alu_ctl = ALU_SUB;
      2'b10: begin
        case (funct)
          6'b100010: alu_ctl = ALU_SUB;
          6'b100100: alu_ctl = ALU_AND;
          6'b100101: alu_ctl = ALU_OR;
          6'b101010: alu_ctl = ALU_SLT;
          default:   alu_ctl = ALU_ADD;
        endcase
      end
      default: alu_ctl = ALU_ADD;
    endcase
  end

  // ALU: wrapping arithmetic, signed set-less-than.
  always_comb begin
    alu_b = alu_src ? imm_sext : rt_val;
    case (alu_ctl)
      ALU_AND: alu_res = rs_val & alu_b;
      ALU_OR:  alu_res = rs_val | alu_b;
      ALU_SUB: alu_res = rs_val - alu_b;
      ALU_SLT: alu_res = {31'd0, ($signed(rs_val) < $signed(alu_b))};
      default: alu_res = rs_val + alu_b;
    endcase
  end

  assign zero = (alu_res == 32'd0);

  // Write-back muxes and next-PC selection.
  always_comb begin
    case (reg_dst)
      2'b01:   rf_wa = rd;
      2'b10:   rf_wa = 5'd31;
      default: rf_wa = rt;
    endcase
    case (mem_to_reg)
      2'b01:   rf_wd = mem_rdat;
      2'b10:   rf_wd = pc_plus4;
      default: rf_wd = alu_res;
    endcase
    if (jump)
      pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch && zero)
      pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
    else
      pc_d = pc_plus4;
  end

  // Program counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  // Register file write port; writes to $0 are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we && (rf_wa != 5'd0)) begin
      rf_q[rf_wa] <= rf_wd;
    end
  end

  // Data memory write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DMEM_WORDS; i++) dmem_q[i] <= '0;
    end else if (mem_we) begin
      dmem_q[alu_res[DAW+1:2]] <= rt_val;
    end
  end

`ifdef MIPS_TRACE_EN
  // Retirement trace: values seen are the ones about to be committed on this edge.
  always @(posedge clk) begin
    if (!reset)
      $display("%0t pc=%08h instr=%08h rf_we=%0b r%0d=%08h mem_we=%0b [%08h]=%08h",
               $time, pc_q, instr, rf_we && (rf_wa != 5'd0), rf_wa, rf_wd, mem_we, alu_res, rt_val);
  end
`else
  // No trace logic in the default build.
`endif

endmodule

// File: tb/tb_mips_single_cycle_core.sv
// Directed bench for mips_single_cycle_core: programs are written into imem while reset is held.
// Each task loads a program, runs a fixed number of edges and checks architectural state.
// Expected values are hand-computed from the instruction semantics.
module tb_mips_single_cycle_core;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr;
  int          n_cmp;
  int          n_bad;

  localparam int OP_R    = 6'b000000;
  localparam int OP_ADDI = 6'b001000;
  localparam int OP_LW   = 6'b100011;
  localparam int OP_SW   = 6'b101011;
  localparam int OP_BEQ  = 6'b000100;
  localparam int OP_J    = 6'b000010;
  localparam int OP_JAL  = 6'b000011;
  localparam int F_ADD   = 6'b100000;
  localparam int F_SUB   = 6'b100010;
  localparam int F_AND   = 6'b100100;
  localparam int F_OR    = 6'b100101;
  localparam int F_SLT   = 6'b101010;

  mips_single_cycle_core #(
    .IMEM_WORDS(64),
    .DMEM_WORDS(64),
    .IMEM_FILE ("program.hex")
  ) dut (
    .clk  (clk),
    .reset(reset),
    .pc   (pc),
    .instr(instr)
  );

  initial clk = 1'b0;
  always #3 clk = ~clk;

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int fn);
    logic [5:0] f6;
    logic [4:0] s5, t5, d5;
    f6 = fn[5:0]; s5 = rs[4:0]; t5 = rt[4:0]; d5 = rd[4:0];
    return {6'b000000, s5, t5, d5, 5'd0, f6};
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
    logic [5:0]  o6;
    logic [4:0]  s5, t5;
    logic [15:0] i16;
    o6 = op[5:0]; s5 = rs[4:0]; t5 = rt[4:0]; i16 = imm[15:0];
    return {o6, s5, t5, i16};
  endfunction

  function automatic logic [31:0] j_ins(input int op, input int target);
    logic [5:0]  o6;
    logic [25:0] t26;
    o6 = op[5:0]; t26 = target[25:0];
    return {o6, t26};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) dut.imem[i] = 32'd0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_imem();
    dut.imem[0] = i_ins(OP_ADDI, 0, 1, 11);
    dut.imem[1] = i_ins(OP_SW, 0, 1, 4);
    #1 reset = 1'b0;
    #9;
    n_cmp++; if (pc !== 32'd8) begin n_bad++; $display("FAIL pre_reset_pc: got %h want 00000008", pc); end
    n_cmp++; if (dut.rf_q[1] !== 32'd11) begin n_bad++; $display("FAIL pre_reset_r1: got %h want 0000000b", dut.rf_q[1]); end
    n_cmp++; if (dut.dmem_q[1] !== 32'd11) begin n_bad++; $display("FAIL pre_reset_m1: got %h want 0000000b", dut.dmem_q[1]); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (pc !== 32'd0) begin n_bad++; $display("FAIL reset_pc: got %h want 00000000", pc); end
    n_cmp++; if (instr !== i_ins(OP_ADDI, 0, 1, 11)) begin n_bad++; $display("FAIL reset_instr: got %h want %h", instr, i_ins(OP_ADDI, 0, 1, 11)); end
    n_cmp++; if (dut.rf_q[1] !== 32'd0) begin n_bad++; $display("FAIL reset_r1: got %h want 00000000", dut.rf_q[1]); end
    n_cmp++; if (dut.dmem_q[1] !== 32'd0) begin n_bad++; $display("FAIL reset_m1: got %h want 00000000", dut.dmem_q[1]); end
    #1 reset = 1'b0;
  endtask

  task automatic test_alu();
    reset = 1'b1;
    clear_imem();
    dut.imem[0] = i_ins(OP_ADDI, 0, 1, 11);
    dut.imem[1] = i_ins(OP_ADDI, 0, 2, 7);
    dut.imem[2] = r_ins(1, 2, 3, F_ADD);
    dut.imem[3] = r_ins(1, 2, 4, F_SUB);
    dut.imem[4] = r_ins(1, 2, 5, F_AND);
    dut.imem[5] = r_ins(1, 2, 6, F_OR);
    dut.imem[6] = r_ins(1, 2, 7, F_SLT);
    dut.imem[7] = r_ins(2, 1, 8, F_SLT);
    run(1);
    n_cmp++; if (pc !== 32'd0) begin n_bad++; $display("FAIL reset_hold_pc: got %h want 00000000", pc); end
    n_cmp++; if (dut.rf_q[1] !== 32'd0) begin n_bad++; $display("FAIL reset_hold_r1: got %h want 00000000", dut.rf_q[1]); end
    release_reset();
    run(8);
    n_cmp++; if (pc !== 32'd32) begin n_bad++; $display("FAIL alu_pc: got %h want 00000020", pc); end
    n_cmp++; if (dut.rf_q[3] !== 32'd18) begin n_bad++; $display("FAIL alu_add: got %0d want 18", dut.rf_q[3]); end
    n_cmp++; if (dut.rf_q[4] !== 32'd4) begin n_bad++; $display("FAIL alu_sub: got %0d want 4", dut.rf_q[4]); end
    n_cmp++; if (dut.rf_q[5] !== 32'd3) begin n_bad++; $display("FAIL alu_and: got %0d want 3", dut.rf_q[5]); end
    n_cmp++; if (dut.rf_q[6] !== 32'd15) begin n_bad++; $display("FAIL alu_or: got %0d want 15", dut.rf_q[6]); end
    n_cmp++; if (dut.rf_q[7] !== 32'd0) begin n_bad++; $display("FAIL alu_slt_false: got %0d want 0", dut.rf_q[7]); end
    n_cmp++; if (dut.rf_q[8] !== 32'd1) begin n_bad++; $display("FAIL alu_slt_true: got %0d want 1", dut.rf_q[8]); end
  endtask

  task automatic test_memory();
    reset = 1'b1;
    clear_imem();
    dut.imem[0] = i_ins(OP_ADDI, 0, 1, 11);
    dut.imem[1] = i_ins(OP_SW, 0, 1, 4);
    dut.imem[2] = i_ins(OP_LW, 0, 9, 4);
    dut.imem[3] = i_ins(OP_ADDI, 0, 0, 5);
    dut.imem[4] = i_ins(OP_ADDI, 0, 10, 22);
    dut.imem[5] = i_ins(OP_SW, 0, 10, 258);   // word 64 wraps to word 0, low bits ignored
    dut.imem[6] = i_ins(OP_LW, 0, 11, 3);     // word 0
    release_reset();
    run(7);
    n_cmp++; if (dut.dmem_q[1] !== 32'd11) begin n_bad++; $display("FAIL mem_sw: got %h want 0000000b", dut.dmem_q[1]); end
    n_cmp++; if (dut.rf_q[9] !== 32'd11) begin n_bad++; $display("FAIL mem_lw: got %h want 0000000b", dut.rf_q[9]); end
    n_cmp++; if (dut.rf_q[0] !== 32'd0) begin n_bad++; $display("FAIL mem_r0_write: got %h want 00000000", dut.rf_q[0]); end
    n_cmp++; if (dut.dmem_q[0] !== 32'd22) begin n_bad++; $display("FAIL mem_sw_wrap: got %h want 00000016", dut.dmem_q[0]); end
    n_cmp++; if (dut.rf_q[11] !== 32'd22) begin n_bad++; $display("FAIL mem_lw_lowbits: got %h want 00000016", dut.rf_q[11]); end
  endtask

  task automatic test_beq();
    reset = 1'b1;
    clear_imem();
    dut.imem[0] = i_ins(OP_ADDI, 0, 1, 5);
    dut.imem[1] = i_ins(OP_ADDI, 0, 2, 5);
    dut.imem[2] = i_ins(OP_BEQ, 1, 2, 2);
    dut.imem[3] = i_ins(OP_ADDI, 0, 3, 1);
    dut.imem[4] = i_ins(OP_ADDI, 0, 4, 1);
    dut.imem[5] = i_ins(OP_BEQ, 1, 0, 3);
    dut.imem[6] = i_ins(OP_ADDI, 0, 5, 9);
    dut.imem[7] = i_ins(OP_BEQ, 0, 0, -1);
    release_reset();
    run(3);
    n_cmp++; if (pc !== 32'd20) begin n_bad++; $display("FAIL beq_taken_pc: got %h want 00000014", pc); end
    run(1);
    n_cmp++; if (pc !== 32'd24) begin n_bad++; $display("FAIL beq_not_taken_pc: got %h want 00000018", pc); end
    run(1);
    n_cmp++; if (dut.rf_q[5] !== 32'd9) begin n_bad++; $display("FAIL beq_fallthrough: got %h want 00000009", dut.rf_q[5]); end
    n_cmp++; if (dut.rf_q[3] !== 32'd0) begin n_bad++; $display("FAIL beq_skip_r3: got %h want 00000000", dut.rf_q[3]); end
    n_cmp++; if (dut.rf_q[4] !== 32'd0) begin n_bad++; $display("FAIL beq_skip_r4: got %h want 00000000", dut.rf_q[4]); end
    run(2);
    n_cmp++; if (pc !== 32'd28) begin n_bad++; $display("FAIL beq_neg_offset: got %h want 0000001c", pc); end
  endtask

  task automatic test_jump_wrap();
    logic [31:0] bad_op;
    bad_op = i_ins(6'h3F, 0, 8, 5);
    reset = 1'b1;
    clear_imem();
    dut.imem[0]  = j_ins(OP_J, 10);
    dut.imem[10] = j_ins(OP_J, 4);
    dut.imem[4]  = j_ins(OP_JAL, 11);
    dut.imem[11] = i_ins(OP_ADDI, 0, 1, -1);
    dut.imem[12] = i_ins(OP_ADDI, 0, 2, 1);
    dut.imem[13] = r_ins(1, 2, 3, F_SLT);
    dut.imem[14] = r_ins(2, 1, 4, F_SLT);
    dut.imem[15] = bad_op;
    dut.imem[16] = r_ins(1, 2, 6, 6'b100001);
    dut.imem[17] = r_ins(1, 1, 7, F_ADD);
    dut.imem[18] = i_ins(OP_SW, 0, 1, -4);
    release_reset();
    run(1);
    n_cmp++; if (pc !== 32'h28) begin n_bad++; $display("FAIL j_pc: got %h want 00000028", pc); end
    run(1);
    n_cmp++; if (pc !== 32'h10) begin n_bad++; $display("FAIL j_back_pc: got %h want 00000010", pc); end
    run(1);
    n_cmp++; if (pc !== 32'h2C) begin n_bad++; $display("FAIL jal_pc: got %h want 0000002c", pc); end
    n_cmp++; if (dut.rf_q[31] !== 32'h14) begin n_bad++; $display("FAIL jal_link: got %h want 00000014", dut.rf_q[31]); end
    run(4);
    n_cmp++; if (instr !== bad_op) begin n_bad++; $display("FAIL fetch_instr: got %h want %h", instr, bad_op); end
    run(1);
    n_cmp++; if (pc !== 32'h40) begin n_bad++; $display("FAIL bad_op_pc: got %h want 00000040", pc); end
    run(3);
    n_cmp++; if (pc !== 32'h4C) begin n_bad++; $display("FAIL wrap_pc: got %h want 0000004c", pc); end
    n_cmp++; if (dut.rf_q[1] !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL addi_neg: got %h want ffffffff", dut.rf_q[1]); end
    n_cmp++; if (dut.rf_q[3] !== 32'd1) begin n_bad++; $display("FAIL slt_neg: got %h want 00000001", dut.rf_q[3]); end
    n_cmp++; if (dut.rf_q[4] !== 32'd0) begin n_bad++; $display("FAIL slt_pos: got %h want 00000000", dut.rf_q[4]); end
    n_cmp++; if (dut.rf_q[8] !== 32'd0) begin n_bad++; $display("FAIL bad_op_nop: got %h want 00000000", dut.rf_q[8]); end
    n_cmp++; if (dut.rf_q[6] !== 32'd0) begin n_bad++; $display("FAIL bad_funct_nop: got %h want 00000000", dut.rf_q[6]); end
    n_cmp++; if (dut.rf_q[7] !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL add_wrap: got %h want fffffffe", dut.rf_q[7]); end
    n_cmp++; if (dut.dmem_q[63] !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sw_neg_addr: got %h want ffffffff", dut.dmem_q[63]); end
    n_cmp++; if (dut.rf_q[31] !== 32'h14) begin n_bad++; $display("FAIL link_kept: got %h want 00000014", dut.rf_q[31]); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    test_reset();
    test_alu();
    test_memory();
    test_beq();
    test_jump_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
